// File: rtl/morse_pkg.sv
// Shared Morse definitions: character code width, code constants, validity
// helper and the letter-handshake FSM encoding.
package morse_pkg;

    localparam int CW = 5;

    localparam logic [CW-1:0] CHAR_START = 5'd0;
    localparam logic [CW-1:0] CHAR_A = 5'd1,  CHAR_B = 5'd2,  CHAR_C = 5'd3,  CHAR_D = 5'd4;
    localparam logic [CW-1:0] CHAR_E = 5'd5,  CHAR_F = 5'd6,  CHAR_G = 5'd7,  CHAR_H = 5'd8;
    localparam logic [CW-1:0] CHAR_I = 5'd9,  CHAR_J = 5'd10, CHAR_K = 5'd11, CHAR_L = 5'd12;
    localparam logic [CW-1:0] CHAR_M = 5'd13, CHAR_N = 5'd14, CHAR_O = 5'd15, CHAR_P = 5'd16;
    localparam logic [CW-1:0] CHAR_Q = 5'd17, CHAR_R = 5'd18, CHAR_S = 5'd19, CHAR_T = 5'd20;
    localparam logic [CW-1:0] CHAR_U = 5'd21, CHAR_V = 5'd22, CHAR_W = 5'd23, CHAR_X = 5'd24;
    localparam logic [CW-1:0] CHAR_Y = 5'd25, CHAR_Z = 5'd26;
    localparam logic [CW-1:0] CHAR_UNKNOWN = 5'd31;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_ACK      = 2'd1,
        HS_WAIT_LOW = 2'd2
    } hs_state_t;

    function automatic logic is_valid_char(input logic [CW-1:0] code);
        return (code >= CHAR_A) && (code <= CHAR_Z);
    endfunction

endpackage

// File: rtl/morse_char_ram.sv
// DEPTH x CW letter store: one synchronous write port, one registered read
// port whose output is forced to blank when the caller masks the read.
module morse_char_ram #(
    parameter int DEPTH = 16,
    parameter int CW    = 5,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [IW-1:0] i_wr_addr,
    input  logic [CW-1:0] i_wr_data,
    input  logic [IW-1:0] i_rd_addr,
    input  logic          i_rd_valid,
    output logic [CW-1:0] o_rd_data
);

    logic [CW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_rd_data;

    // Storage carries no reset; stale entries are hidden by the occupancy mask.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= i_rd_valid ? r_mem[i_rd_addr] : '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/morse_msg_buffer.sv
// Message buffer behind the Morse letter decoder: captures letters over the
// done/ack handshake, supports delete-last and clear, exposes a read port.
module morse_msg_buffer
    import morse_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = morse_pkg::CW,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] ch_in,
    input  logic          ch_done,
    output logic          ch_ack,
    input  logic          clr,
    input  logic          del,
    input  logic [IW-1:0] rd_idx,
    output logic [CW-1:0] rd_char,
    output logic [IW:0]   count,
    output logic          full,
    output logic          overflow,
    output logic          bad_char
);

    localparam logic [IW:0] FULL_COUNT = (IW+1)'(DEPTH);

    hs_state_t   r_state, w_state_next;
    logic [IW:0] r_count;
    logic        r_overflow, r_bad_char;
    logic        w_accept, w_valid, w_full, w_we, w_rd_valid;

    assign w_valid    = is_valid_char(ch_in);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_we       = w_accept && w_valid && !w_full;
    assign w_rd_valid = ({1'b0, rd_idx} < r_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Commands win over capture; a blocked letter stays pending on ch_done.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (ch_done && !clr && !del) begin
                    w_accept     = 1'b1;
                    w_state_next = HS_ACK;
                end
            end
            HS_ACK:      w_state_next = HS_WAIT_LOW;
            HS_WAIT_LOW: if (!ch_done) w_state_next = HS_IDLE;
            default:     w_state_next = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bad_char <= 1'b0;
        end else if (clr) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_bad_char <= 1'b0;
        end else if (del) begin
            if (r_count != '0) r_count <= r_count - 1'b1;
        end else if (w_accept) begin
            if (!w_valid)     r_bad_char <= 1'b1;
            else if (w_full)  r_overflow <= 1'b1;
            else              r_count    <= r_count + 1'b1;
        end
    end

    morse_char_ram #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .IW    (IW)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_we),
        .i_wr_addr  (r_count[IW-1:0]),
        .i_wr_data  (ch_in),
        .i_rd_addr  (rd_idx),
        .i_rd_valid (w_rd_valid),
        .o_rd_data  (rd_char)
    );

    assign ch_ack   = (r_state == HS_ACK);
    assign count    = r_count;
    assign full     = w_full;
    assign overflow = r_overflow;
    assign bad_char = r_bad_char;

endmodule
